// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D scan scheduler.
// Holds the FSM state encoding, request source and command word builder.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT1,
    GAP,
    READ,
    WAIT2
  } a2d_state_t;

  typedef enum logic {
    SCAN,
    HOST
  } src_t;

  localparam logic [15:0] CMD_BASE = 16'h0000;

  function automatic logic [15:0] mk_cmd(input logic [2:0] chnl);
    return CMD_BASE | {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_tick_gen.sv
// Scan period timer with a pending-tick flag and sticky overrun.
// A tick that lands while one is still pending raises overrun.
module a2d_tick_gen #(
  parameter int PERIOD = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scan_en,
  input  logic take,
  input  logic clr_ovr,
  output logic tick_pend,
  output logic overrun
);

  localparam int TW = $clog2(PERIOD);

  logic [TW-1:0] timer;
  logic          wrap;
  logic          ovr_evt;

  assign wrap    = scan_en && (timer == TW'(PERIOD - 1));
  assign ovr_evt = wrap && tick_pend && !take;

  // Timer, pending tick and overrun; a new tick refills a slot being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      tick_pend <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (!scan_en || wrap) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if (wrap) begin
        tick_pend <= 1'b1;
      end else if (take) begin
        tick_pend <= 1'b0;
      end
      if (ovr_evt) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/a2d_scan_sched.sv
// Drives the SPI master to convert A2D channels: periodic round-robin
// scan into a result file plus prioritised one-shot host conversions.
module a2d_scan_sched
  import a2d_pkg::*;
#(
  parameter int PERIOD  = 1024,
  parameter int NUM_CH  = 8,
  parameter int GAP_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        host_req,
  input  logic [2:0]  host_chnl,
  output logic        host_ack,
  output logic [11:0] host_data,
  input  logic [2:0]  rd_chnl,
  output logic [11:0] rd_data,
  output logic        sample_vld,
  output logic [2:0]  sample_chnl,
  output logic        overrun,
  input  logic        clr_ovr,
  output logic        busy,
  output logic [15:0] spi_cmd,
  output logic        spi_wrt,
  input  logic        spi_done,
  input  logic [15:0] spi_data
);

  localparam int         GW   = $clog2(GAP_CYC);
  localparam logic [2:0] LAST = 3'(NUM_CH - 1);

  a2d_state_t    state;
  src_t          src;
  logic [2:0]    ch;
  logic [2:0]    rr_ptr;
  logic [GW-1:0] gap_cnt;
  logic [11:0]   rf [8];
  logic          tick_pend;
  logic          take;
  logic          unused_hi;

  assign take      = (state == IDLE) && !host_req && tick_pend;
  assign busy      = (state != IDLE);
  assign rd_data   = rf[rd_chnl];
  assign unused_hi = ^spi_data[15:12];

  a2d_tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_en  (scan_en),
    .take     (take),
    .clr_ovr  (clr_ovr),
    .tick_pend(tick_pend),
    .overrun  (overrun)
  );

  // Conversion sequencer: command, gap, readback, then store the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      src         <= SCAN;
      ch          <= '0;
      rr_ptr      <= '0;
      gap_cnt     <= '0;
      spi_cmd     <= '0;
      spi_wrt     <= 1'b0;
      host_ack    <= 1'b0;
      host_data   <= '0;
      sample_vld  <= 1'b0;
      sample_chnl <= '0;
      for (int i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else begin
      spi_wrt    <= 1'b0;
      host_ack   <= 1'b0;
      sample_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host_req) begin
            ch    <= host_chnl;
            src   <= HOST;
            state <= CMD;
          end else if (tick_pend) begin
            ch    <= rr_ptr;
            src   <= SCAN;
            state <= CMD;
          end
        end
        CMD: begin
          spi_cmd <= mk_cmd(ch);
          spi_wrt <= 1'b1;
          state   <= WAIT1;
        end
        WAIT1: begin
          if (spi_done) begin
            gap_cnt <= GW'(GAP_CYC - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= READ;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        READ: begin
          spi_cmd <= mk_cmd(ch);
          spi_wrt <= 1'b1;
          state   <= WAIT2;
        end
        WAIT2: begin
          if (spi_done) begin
            if (src == HOST) begin
              host_data <= spi_data[11:0];
              host_ack  <= 1'b1;
            end else begin
              rf[ch]      <= spi_data[11:0];
              sample_chnl <= ch;
              sample_vld  <= 1'b1;
              rr_ptr      <= (rr_ptr == LAST) ? 3'd0
                                              : rr_ptr + 3'd1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/a2d_scan_sched.md
Name: a2d_scan_sched

Overview:
- Sequences the SPI master to run an 8-channel SPI A2D converter.
- Scans channels round-robin on a periodic tick and stores each 12-bit result in an internal result file.
- Serves one-shot host conversion requests, which take priority over the scan.
- Sits between the SPI master (cmd/wrt/done/data) and the sensor-processing logic.

Parameters:
PERIOD, 1024, clk cycles between scan ticks (>=64)
NUM_CH, 8, number of channels scanned, 1..8
GAP_CYC, 8, idle clks between the command and readback transactions (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scan_en  in  1  enables tick generation and scanning
host_req  in  1  level request for a host conversion; held until host_ack
host_chnl  in  3  channel for host_req; sampled when accepted
host_ack  out  1  1-clk pulse, result valid on host_data
host_data  out  12  result of last host conversion
rd_chnl  in  3  result-file read address
rd_data  out  12  result_file[rd_chnl], combinational read
sample_vld  out  1  1-clk pulse when a scan result is written
sample_chnl  out  3  channel of the current/last scan result
overrun  out  1  sticky: tick arrived while a tick was already pending
clr_ovr  in  1  clears overrun
busy  out  1  high in any state other than IDLE
spi_cmd  out  16  command word to the SPI master
spi_wrt  out  1  1-clk start pulse to the SPI master
spi_done  in  1  1-clk done pulse from the SPI master
spi_data  in  16  data returned by the SPI master; valid in the cycle spi_done=1

Behaviour:
- Reset: all outputs 0; result file 0; rr_ptr=0; timer=0; tick_pend=0; state=IDLE.
- Timer:
  - Counts only while scan_en=1.
  - At PERIOD-1: reloads to 0. If tick_pend=0 it sets tick_pend; otherwise it sets overrun.
  - scan_en=0: timer clears; tick_pend is kept.
- clr_ovr clears overrun. If clr_ovr and an overrun event occur in the same cycle, the set wins.
- Command word = {2'b00, chnl[2:0], 11'h000}. Readback uses the same word.
- FSM states: IDLE, CMD, WAIT1, GAP, READ, WAIT2.
  - IDLE: if host_req=1, latch host_chnl and set src=HOST. Else if tick_pend=1, latch rr_ptr, set src=SCAN and clear tick_pend. Either way go to CMD. Host wins any simultaneous request.
  - CMD: drive spi_cmd, pulse spi_wrt for exactly 1 clk, go to WAIT1. spi_cmd holds until the next CMD/READ.
  - WAIT1: on spi_done, load the gap counter and go to GAP. Returned data is discarded.
  - GAP: count GAP_CYC clks, then go to READ.
  - READ: pulse spi_wrt with the same command word, go to WAIT2.
  - WAIT2: on spi_done, capture result = spi_data[11:0], then go to IDLE.
    - src=HOST: host_data<=result, host_ack=1.
    - src=SCAN: result_file[ch]<=result, sample_chnl<=ch, sample_vld=1, rr_ptr<=(rr_ptr==NUM_CH-1)?0:rr_ptr+1.
- Latency from IDLE accept to ack/vld: 2 SPI transactions + GAP_CYC + 4 clks.
- host_ack and sample_vld are registered and asserted in the clk after WAIT2 sees spi_done.
- host_req must stay high until host_ack. A request already accepted completes even if host_req drops.
- scan_en deasserted mid-conversion: the current conversion completes and is stored. No new scan starts while tick_pend=0.
- spi_done outside WAIT1/WAIT2 is ignored.
- Reset mid-operation: everything returns to reset values immediately. spi_wrt must not glitch high.
- rr_ptr only advances on a completed scan conversion. Host conversions never advance it.

Decomposition:
- Package a2d_pkg holds:
  - state enum (2'b..3 bits) a2d_state_t
  - src_t {SCAN, HOST}
  - CMD_BASE constant and a function mk_cmd(chnl) returning the 16-bit word
- One natural sub-module: a2d_tick_gen (timer + tick_pend + overrun), parameterised by PERIOD.

Test Plan:
- Scan: PERIOD=64, scan_en=1, SPI model returns 16'h0ABC for ch0 -> spi_cmd 16'h0000 twice, separated by >=GAP_CYC idle clks; sample_vld with sample_chnl=0; rd_chnl=0 gives rd_data=12'hABC.
- Wrap: NUM_CH=3, run 4 ticks -> channel order 0,1,2,0; cmd words 16'h0000, 16'h0800, 16'h1000, 16'h0000.
- Priority: host_req=1, host_chnl=5 in the same cycle tick_pend=1 -> host served first, cmd 16'h2800, host_ack with host_data=spi_data[11:0]; the scan runs next on rr_ptr unchanged.
- Overrun: SPI model delays done by >2*PERIOD -> overrun=1 and stays set; clr_ovr pulse -> 0; simultaneous clr_ovr + overrun event -> 1.
- Reset mid-WAIT2: deassert rst_n -> busy=0, spi_wrt=0, result file 0, no sample_vld after release.
- scan_en drop in GAP -> conversion finishes with one sample_vld, then no further spi_wrt for 3*PERIOD.
